// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and constants for the Block Invaders game sequencer
package game_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, HIT = 3'd2, CLEAR = 3'd3, OVER = 3'd4} state_e;
  localparam int SCORE_W_DEF = 14;
  localparam int MAX_WAVE = 7;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/game_flow_ctrl_frame_timer.sv
// frame_timer: counts frame ticks up to a target and holds there until cleared
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         frame_tick,
  input  logic [W-1:0] target,
  output logic [W-1:0] count,
  output logic         done
);
  logic [W-1:0] count_q;
  always_ff @(posedge clk)
    count_q <= (reset || clr) ? '0 : (frame_tick && count_q < target) ? count_q + W'(1) : count_q;
  assign count = count_q;
  assign done = count_q == target;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: play/respawn/wave-clear/game-over sequencer owning lives, score, wave and generator resets
module game_flow_ctrl import game_pkg::*; #(
  parameter int LIVES          = 3,
  parameter int RESPAWN_FRAMES = 90,
  parameter int CLEAR_FRAMES   = 60,
  parameter int OVER_FRAMES    = 180,
  parameter int SCORE_PER_HIT  = 10,
  parameter int SCORE_W        = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               ship_hit,
  input  logic               alien_hit,
  input  logic               wave_clear,
  output logic [2:0]         state,
  output logic               play_en,
  output logic               ship_rst,
  output logic               field_rst,
  output logic [1:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         wave
);
  localparam int CW = $clog2(max3(RESPAWN_FRAMES, CLEAR_FRAMES, OVER_FRAMES) + 1);
  state_e state_q, state_d;
  logic start_q, start_rise;
  logic play_en_q, play_en_d, ship_rst_q, ship_rst_d, field_rst_q, field_rst_d, new_field;
  logic [1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0] sum;
  logic [2:0] wave_q, wave_d;
  logic [CW-1:0] tgt, cnt;
  logic done, tick_last;
  assign start_rise = start & ~start_q;
  assign sum = {1'b0, score_q} + (SCORE_W+1)'(SCORE_PER_HIT);
  assign tgt = (state_q == HIT) ? CW'(RESPAWN_FRAMES) : (state_q == CLEAR) ? CW'(CLEAR_FRAMES) : CW'(OVER_FRAMES);
  // expiry is detected on the final tick itself so the resets land one cycle after it
  assign tick_last = frame_tick & (cnt == tgt - CW'(1));
  frame_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clr        (state_d != state_q),
    .frame_tick (frame_tick),
    .target     (tgt),
    .count      (cnt),
    .done       (done)
  );
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    wave_d = wave_q;
    ship_rst_d = 1'b0;
    new_field = 1'b0;
    case (state_q)
      IDLE: if (start_rise) begin
        state_d = PLAY;
        lives_d = 2'(LIVES);
        score_d = '0;
        wave_d = 3'd1;
        ship_rst_d = 1'b1;
      end
      PLAY: begin
        score_d = alien_hit ? (sum[SCORE_W] ? '1 : sum[SCORE_W-1:0]) : score_q;
        if (ship_hit) begin
          lives_d = lives_q - 2'd1;
          state_d = (lives_q == 2'd1) ? OVER : HIT;
        end else if (wave_clear) state_d = CLEAR;
      end
      HIT: if (tick_last) begin
        state_d = PLAY;
        ship_rst_d = 1'b1;
      end
      CLEAR: if (tick_last) begin
        state_d = PLAY;
        ship_rst_d = 1'b1;
        new_field = 1'b1;
        wave_d = (wave_q < 3'(MAX_WAVE)) ? wave_q + 3'd1 : wave_q;
      end
      OVER: if (done && start_rise) begin
        state_d = IDLE;
        wave_d = '0;
      end
      default: state_d = IDLE;
    endcase
    play_en_d = state_d == PLAY;
    field_rst_d = (state_d == IDLE) | new_field;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      play_en_q <= 1'b0;
      ship_rst_q <= 1'b0;
      field_rst_q <= 1'b1;
      lives_q <= 2'(LIVES);
      score_q <= '0;
      wave_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      play_en_q <= play_en_d;
      ship_rst_q <= ship_rst_d;
      field_rst_q <= field_rst_d;
      lives_q <= lives_d;
      score_q <= score_d;
      wave_q <= wave_d;
    end
  assign state = state_q;
  assign play_en = play_en_q;
  assign ship_rst = ship_rst_q;
  assign field_rst = field_rst_q;
  assign lives = lives_q;
  assign score = score_q;
  assign wave = wave_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed checks of the game sequencer plus a narrow-score saturation instance
module tb_game_flow_ctrl;
  logic clk = 1'b0;
  logic reset, frame_tick, start, ship_hit, alien_hit, wave_clear, a2, zero;
  logic [2:0] state, wave, s_state, s_wave;
  logic play_en, ship_rst, field_rst, s_play_en, s_ship_rst, s_field_rst;
  logic [1:0] lives, s_lives;
  logic [13:0] score;
  logic [5:0] s_score;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  game_flow_ctrl u_dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .ship_hit(ship_hit),
    .alien_hit(alien_hit), .wave_clear(wave_clear), .state(state), .play_en(play_en),
    .ship_rst(ship_rst), .field_rst(field_rst), .lives(lives), .score(score), .wave(wave)
  );
  game_flow_ctrl #(.SCORE_W(6)) u_sat (
    .clk(clk), .reset(reset), .frame_tick(zero), .start(start), .ship_hit(zero),
    .alien_hit(a2), .wave_clear(zero), .state(s_state), .play_en(s_play_en),
    .ship_rst(s_ship_rst), .field_rst(s_field_rst), .lives(s_lives), .score(s_score), .wave(s_wave)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask
  initial begin
    zero = 1'b0; a2 = 1'b0;
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0; ship_hit = 1'b0; alien_hit = 1'b0; wave_clear = 1'b0;
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_play_en", play_en, 0);
    chk("rst_ship_rst", ship_rst, 0);
    chk("rst_field_rst", field_rst, 1);
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 0);
    chk("rst_wave", wave, 0);
    reset = 1'b0; start = 1'b1;
    step();
    chk("start_state", state, 1);
    chk("start_ship_rst", ship_rst, 1);
    chk("start_play_en", play_en, 1);
    chk("start_field_rst", field_rst, 0);
    chk("start_lives", lives, 3);
    chk("start_wave", wave, 1);
    chk("start_score", score, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("start_hold_state", state, 1);
      chk("start_hold_ship_rst", ship_rst, 0);
    end
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      a2 = 1'b1;
      step();
      chk("sat_score", s_score, (i * 10 > 63) ? 63 : i * 10);
    end
    a2 = 1'b0;
    alien_hit = 1'b1;
    step(); step(); step(); step();
    chk("score_4_hits", score, 40);
    ship_hit = 1'b1;
    step();
    alien_hit = 1'b0; ship_hit = 1'b0;
    chk("hit_score", score, 50);
    chk("hit_lives", lives, 2);
    chk("hit_state", state, 2);
    chk("hit_play_en", play_en, 0);
    ticks(89);
    chk("hit_89_state", state, 2);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("respawn_state", state, 1);
    chk("respawn_ship_rst", ship_rst, 1);
    chk("respawn_play_en", play_en, 1);
    chk("respawn_field_rst", field_rst, 0);
    step();
    chk("respawn_ship_rst_end", ship_rst, 0);
    wave_clear = 1'b1; ship_hit = 1'b1;
    step();
    wave_clear = 1'b0; ship_hit = 1'b0;
    chk("both_state", state, 2);
    chk("both_wave", wave, 1);
    chk("both_lives", lives, 1);
    ticks(90);
    chk("both_back_state", state, 1);
    wave_clear = 1'b1;
    step();
    wave_clear = 1'b0;
    chk("clear_state", state, 3);
    alien_hit = 1'b1; ship_hit = 1'b1;
    step();
    alien_hit = 1'b0; ship_hit = 1'b0;
    chk("clear_ignore_score", score, 50);
    chk("clear_ignore_lives", lives, 1);
    ticks(59);
    chk("clear_59_state", state, 3);
    chk("clear_59_wave", wave, 1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("clear_exit_state", state, 1);
    chk("clear_exit_field_rst", field_rst, 1);
    chk("clear_exit_ship_rst", ship_rst, 1);
    chk("clear_exit_wave", wave, 2);
    step();
    chk("clear_field_rst_end", field_rst, 0);
    for (int i = 0; i < 6; i++) begin
      wave_clear = 1'b1;
      step();
      wave_clear = 1'b0;
      ticks(60);
    end
    chk("wave_cap", wave, 7);
    chk("wave_cap_state", state, 1);
    ship_hit = 1'b1;
    step();
    ship_hit = 1'b0;
    chk("over_state", state, 4);
    chk("over_lives", lives, 0);
    chk("over_score", score, 50);
    ticks(100);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("over_early_start", state, 4);
    ticks(79);
    frame_tick = 1'b1; start = 1'b1;
    step();
    frame_tick = 1'b0; start = 1'b0;
    chk("over_expiry_start", state, 4);
    step();
    start = 1'b1;
    step();
    chk("over_to_idle", state, 0);
    chk("idle_wave", wave, 0);
    chk("idle_field_rst", field_rst, 1);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk("restart_state", state, 1);
    chk("restart_score", score, 0);
    alien_hit = 1'b1;
    step();
    alien_hit = 1'b0; ship_hit = 1'b1;
    step();
    ship_hit = 1'b0;
    chk("rst2_pre_state", state, 2);
    chk("rst2_pre_score", score, 10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_state", state, 0);
    chk("rst2_score", score, 0);
    chk("rst2_lives", lives, 3);
    chk("rst2_field_rst", field_rst, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Game-level sequencer for Block Invaders. It owns the play/respawn/wave-clear/game-over state machine, lives and score. It also gates and re-initialises the ship/laser generator and the alien field. It sits between the raw collision pulses from the object generators and the reset/enable inputs of those generators, and feeds lives/score/wave to the display mux.

## Interface
- LIVES, 3, starting lives; legal range 1..3.
- RESPAWN_FRAMES, 90, frame ticks frozen after a ship hit.
- CLEAR_FRAMES, 60, frame ticks frozen after a wave is cleared.
- OVER_FRAMES, 180, minimum frame ticks held in OVER.
- SCORE_PER_HIT, 10, points added per alien hit.
- SCORE_W, 14, score width.
- clk  in  1  pixel clock, the same clock as the ship/laser generator.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame, asserted at y==481, x==0.
- start  in  1  start button level, already debounced.
- ship_hit  in  1  one-cycle pulse: alien shot hit the ship.
- alien_hit  in  1  one-cycle pulse: laser hit an alien.
- wave_clear  in  1  level: no aliens remain.
- state  out  3  current FSM state encoding.
- play_en  out  1  movement and shooting enable for the generators.
- ship_rst  out  1  one-cycle pulse that re-centres the ship and laser.
- field_rst  out  1  alien field reset; a level in IDLE, a pulse elsewhere.
- lives  out  2  remaining lives.
- score  out  SCORE_W  saturating score.
- wave  out  3  wave number; 1..7, 0 in IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - state=IDLE, play_en=0, ship_rst=0, field_rst=1.
  - lives=LIVES, score=0, wave=0.
  - Frame counter=0, start_q=0.
- Start edge: start_q registers start each cycle. start_rise = start & ~start_q.
- IDLE:
  - field_rst=1, play_en=0.
  - On start_rise: go to PLAY, lives=LIVES, score=0, wave=1.
  - Pulse ship_rst on the transition cycle.
  - Deassert field_rst on the transition cycle.
- PLAY:
  - play_en=1.
  - alien_hit: score += SCORE_PER_HIT, saturating at 2^SCORE_W-1.
  - ship_hit with lives==1: lives=0, go to OVER.
  - ship_hit with lives>1: lives−1, go to HIT.
  - wave_clear with no ship_hit: go to CLEAR.
  - Priority is ship_hit > wave_clear.
  - An alien_hit in the same cycle as ship_hit or wave_clear is still scored.
- HIT:
  - play_en=0. Count frame_tick.
  - On the RESPAWN_FRAMES-th tick: pulse ship_rst, go to PLAY.
  - The alien field is not reset.
- CLEAR:
  - play_en=0. Count frame_tick.
  - On the CLEAR_FRAMES-th tick: pulse ship_rst and field_rst together, go to PLAY.
  - wave increments, saturating at 7.
- OVER:
  - play_en=0. Count frame_tick up to OVER_FRAMES, then hold.
  - A start_rise after expiry goes to IDLE. A start_rise before expiry is ignored.
  - score and lives hold for display.
- Pulse inputs outside PLAY are ignored: ship_hit, alien_hit, wave_clear.
- The frame counter clears on every state change.
- Counter width is $clog2(max(RESPAWN_FRAMES, CLEAR_FRAMES, OVER_FRAMES)+1).
- Reset mid-operation returns all registers to reset values on the next edge, from any state.

## Timing
- Input to output latency is one clock: a pulse sampled at edge N is visible on state, lives and score after edge N.
- ship_rst and field_rst pulses are exactly one clk wide, asserted in the cycle after the counter-expiry frame_tick edge.
- play_en rises in the same cycle as the ship_rst pulse.
- Frame counting:
  - HIT lasts exactly RESPAWN_FRAMES frame_ticks.
  - CLEAR lasts exactly CLEAR_FRAMES frame_ticks.
  - OVER lasts at least OVER_FRAMES frame_ticks.
  - A frame_tick in the entry cycle counts.
- frame_tick and start_rise arriving together in OVER at expiry: expiry is registered first, so start must rise on a later cycle.

## Structure
- Package game_pkg holds:
  - state localparams: IDLE=0, PLAY=1, HIT=2, CLEAR=3, OVER=4.
  - the SCORE_W default.
  - the MAX_WAVE=7 constant.
- Sub-module frame_timer:
  - inputs: clk, reset, clr, frame_tick, target.
  - outputs: count and done (level, held at target).
  - It is instantiated once and shared by HIT, CLEAR and OVER.
- The FSM, score adder and lives counter stay in game_flow_ctrl.

## Test plan
- Reset, then start high for 5 cycles:
  - state IDLE→PLAY exactly once.
  - one ship_rst pulse.
  - lives=3, wave=1, score=0, field_rst low.
- In PLAY, 4 alien_hit pulses, then ship_hit coincident with alien_hit:
  - score=50, lives=2, state=HIT.
  - after 90 frame_ticks: ship_rst pulse, PLAY.
- Score saturation with SCORE_W=6, SCORE_PER_HIT=10, 7 hits: score=63 and holds.
- wave_clear and ship_hit in the same cycle: state=HIT, wave unchanged.
- wave_clear alone:
  - CLEAR for 60 ticks, then field_rst and ship_rst pulse together, wave=2.
  - repeated clears cap wave at 7.
- Three ship_hits: state=OVER, lives=0.
  - start at tick 100 is ignored.
  - start after tick 180 goes to IDLE.
  - reset asserted in HIT returns IDLE, score 0.
